// File: rtl/pipeline_buffer.sv
// pipeline_buffer: DEPTH-stage register pipeline with stall, flush and
// deferred zero-bubble insertion, plus a saturating stalled-output counter.
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         asynchronous active-low reset, clears all state
//   w_en          1 = shift the pipeline, 0 = hold (stall)
//   bubble        load the bubble counter with BUBBLE_LEN
//   flush         synchronous clear of stages, valid bits, bubbles, stall count
//   valid_in      qualifies buffer_in
//   buffer_in     [N-1:0] data entering stage 0
//   buffer_out    [N-1:0] registered data of the last stage
//   valid_out     registered valid bit of the last stage
//   bubble_active registered, high while the bubble counter is nonzero
//   stall_count   [15:0] saturating count of edges that stalled a valid output
module pipeline_buffer #(
    parameter int N          = 40,
    parameter int DEPTH      = 1,
    parameter int BUBBLE_LEN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         w_en,
    input  logic         bubble,
    input  logic         flush,
    input  logic         valid_in,
    input  logic [N-1:0] buffer_in,
    output logic [N-1:0] buffer_out,
    output logic         valid_out,
    output logic         bubble_active,
    output logic [15:0]  stall_count
);

    localparam logic [2:0] BUBBLE_LOAD = 3'(BUBBLE_LEN);

    logic [N-1:0] data_r  [DEPTH];
    logic [N-1:0] data_s  [DEPTH];
    logic         valid_r [DEPTH];
    logic         valid_s [DEPTH];
    logic [2:0]   cnt_r;
    logic [2:0]   cnt_s;
    logic         bubble_active_r;
    logic [15:0]  stall_r;
    logic [15:0]  stall_s;

    // Saturating 16-bit increment: sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = 16'hFFFF;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    // Next-state logic: flush beats bubble insertion, which beats shift/hold.
    always_comb begin
        data_s  = data_r;
        valid_s = valid_r;
        cnt_s   = cnt_r;
        stall_s = stall_r;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_s[k]  = '0;
                valid_s[k] = 1'b0;
            end
            cnt_s   = 3'd0;
            stall_s = 16'd0;
        end else if (cnt_r != 3'd0) begin
            // Insertion edge: stage 0 is forced to an empty entry even when
            // stalled; the downstream stages still obey w_en.
            if (w_en) begin
                for (int k = 1; k < DEPTH; k++) begin
                    data_s[k]  = data_r[k-1];
                    valid_s[k] = valid_r[k-1];
                end
            end else begin
                data_s  = data_r;
                valid_s = valid_r;
            end
            data_s[0]  = '0;
            valid_s[0] = 1'b0;
            cnt_s      = bubble ? BUBBLE_LOAD : (cnt_r - 3'd1);
        end else begin
            if (w_en) begin
                for (int k = 1; k < DEPTH; k++) begin
                    data_s[k]  = data_r[k-1];
                    valid_s[k] = valid_r[k-1];
                end
                data_s[0]  = buffer_in;
                valid_s[0] = valid_in;
            end else if (valid_r[DEPTH-1]) begin
                stall_s = sat_inc16(stall_r);
            end else begin
                stall_s = stall_r;
            end
            // A request on an idle edge only arms the counter; insertion
            // starts on the following edge.
            cnt_s = bubble ? BUBBLE_LOAD : 3'd0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_r[k]  <= '0;
                valid_r[k] <= 1'b0;
            end
            cnt_r           <= 3'd0;
            bubble_active_r <= 1'b0;
            stall_r         <= 16'd0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                data_r[k]  <= data_s[k];
                valid_r[k] <= valid_s[k];
            end
            cnt_r           <= cnt_s;
            bubble_active_r <= (cnt_s != 3'd0);
            stall_r         <= stall_s;
        end
    end

    assign buffer_out    = data_r[DEPTH-1];
    assign valid_out     = valid_r[DEPTH-1];
    assign bubble_active = bubble_active_r;
    assign stall_count   = stall_r;

endmodule

// File: tb/tb_pipeline_buffer.sv
// Self-checking bench for pipeline_buffer. Three instances with different
// DEPTH / BUBBLE_LEN / N share one stimulus stream; a queue-style model per
// instance is compared against every DUT on each falling clock edge, and
// directed literal expectations pin the behaviour at key points.
module tb_pipeline_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_en;
    logic        bubble;
    logic        flush;
    logic        valid_in;
    logic [39:0] din;

    logic [39:0] out_a;
    logic [7:0]  out_b;
    logic [39:0] out_c;
    logic        vo_a, vo_b, vo_c;
    logic        ba_a, ba_b, ba_c;
    logic [15:0] sc_a, sc_b, sc_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_buffer #(.N(40), .DEPTH(3), .BUBBLE_LEN(2)) dut_a (
        .clk(clk), .reset(reset), .w_en(w_en), .bubble(bubble), .flush(flush),
        .valid_in(valid_in), .buffer_in(din), .buffer_out(out_a),
        .valid_out(vo_a), .bubble_active(ba_a), .stall_count(sc_a));

    pipeline_buffer #(.N(8), .DEPTH(1), .BUBBLE_LEN(1)) dut_b (
        .clk(clk), .reset(reset), .w_en(w_en), .bubble(bubble), .flush(flush),
        .valid_in(valid_in), .buffer_in(din[7:0]), .buffer_out(out_b),
        .valid_out(vo_b), .bubble_active(ba_b), .stall_count(sc_b));

    pipeline_buffer #(.N(40), .DEPTH(2), .BUBBLE_LEN(3)) dut_c (
        .clk(clk), .reset(reset), .w_en(w_en), .bubble(bubble), .flush(flush),
        .valid_in(valid_in), .buffer_in(din), .buffer_out(out_c),
        .valid_out(vo_c), .bubble_active(ba_c), .stall_count(sc_c));

    // ---------------- behavioural model ----------------
    logic [127:0] md    [3][8];
    logic         mv    [3][8];
    int           mcnt  [3];
    int           mstall[3];

    function automatic int dep(input int i);
        case (i)
            0:       return 3;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int blen(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [127:0] mask(input int i);
        int nw;
        nw = (i == 1) ? 8 : 40;
        return (128'd1 << nw) - 128'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 8; k++) begin
                md[i][k] = 128'd0;
                mv[i][k] = 1'b0;
            end
            mcnt[i]   = 0;
            mstall[i] = 0;
        end
    endtask

    // Advance every model by one clock edge using the current inputs.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int d;
            d = dep(i);
            if (flush) begin
                for (int k = 0; k < 8; k++) begin
                    md[i][k] = 128'd0;
                    mv[i][k] = 1'b0;
                end
                mcnt[i]   = 0;
                mstall[i] = 0;
            end else if (mcnt[i] != 0) begin
                if (w_en) begin
                    for (int k = d - 1; k >= 1; k--) begin
                        md[i][k] = md[i][k-1];
                        mv[i][k] = mv[i][k-1];
                    end
                end
                md[i][0] = 128'd0;
                mv[i][0] = 1'b0;
                mcnt[i]  = bubble ? blen(i) : mcnt[i] - 1;
            end else begin
                if (w_en) begin
                    for (int k = d - 1; k >= 1; k--) begin
                        md[i][k] = md[i][k-1];
                        mv[i][k] = mv[i][k-1];
                    end
                    md[i][0] = {88'd0, din} & mask(i);
                    mv[i][0] = valid_in;
                end else if (mv[i][d-1] && mstall[i] < 65535) begin
                    mstall[i] = mstall[i] + 1;
                end
                if (bubble) mcnt[i] = blen(i);
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] got_d(input int i);
        case (i)
            0:       return {88'd0, out_a};
            1:       return {120'd0, out_b};
            default: return {88'd0, out_c};
        endcase
    endfunction

    function automatic logic [3:0] got_flags(input int i);
        case (i)
            0:       return {2'b00, vo_a, ba_a};
            1:       return {2'b00, vo_b, ba_b};
            default: return {2'b00, vo_c, ba_c};
        endcase
    endfunction

    function automatic logic [15:0] got_sc(input int i);
        case (i)
            0:       return sc_a;
            1:       return sc_b;
            default: return sc_c;
        endcase
    endfunction

    // Compare every DUT against its model on each falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [3:0] f;
            f = got_flags(i);
            chk($sformatf("dut%0d buffer_out", i), got_d(i), md[i][dep(i)-1]);
            chk($sformatf("dut%0d valid_out", i), {127'd0, f[1]}, {127'd0, mv[i][dep(i)-1]});
            chk($sformatf("dut%0d bubble_active", i), {127'd0, f[0]}, {127'd0, (mcnt[i] != 0)});
            chk($sformatf("dut%0d stall_count", i), {112'd0, got_sc(i)}, 128'(mstall[i]));
        end
    end

    task automatic cyc(input logic w, input logic b, input logic f, input logic v,
                       input logic [39:0] d);
        w_en     = w;
        bubble   = b;
        flush    = f;
        valid_in = v;
        din      = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        w_en     = 1'b0;
        bubble   = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        din      = 40'd0;
        model_reset();
        #12;
        chk("reset out_a", {88'd0, out_a}, 128'd0);
        chk("reset vo_c", {127'd0, vo_c}, 128'd0);
        chk("reset sc_b", {112'd0, sc_b}, 128'd0);
        reset = 1'b1;

        // Latency through DEPTH=3 and DEPTH=1.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'hA);
        chk("depth1 out edge1", {120'd0, out_b}, 128'hA);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'hB);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'hC);
        chk("depth3 out edge3", {88'd0, out_a}, 128'hA);
        chk("depth3 valid edge3", {127'd0, vo_a}, 128'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 40'h0);
        chk("depth3 out edge4", {88'd0, out_a}, 128'hB);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 40'h0);
        chk("depth3 out edge5", {88'd0, out_a}, 128'hC);

        // Bubble request at edge t, then insertion on the following edges.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 40'h5);
        chk("bubble t out_b", {120'd0, out_b}, 128'h5);
        chk("bubble t ba_c", {127'd0, ba_c}, 128'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 40'h7);
        chk("bubble t+1 out_b", {120'd0, out_b}, 128'h0);
        chk("bubble t+1 vo_b", {127'd0, vo_b}, 128'd0);
        chk("bubble t+1 ba_c", {127'd0, ba_c}, 128'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'h8);
        chk("bubble t+2 ba_c", {127'd0, ba_c}, 128'd1);
        chk("bubble t+2 vo_c", {127'd0, vo_c}, 128'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'h9);
        chk("bubble t+3 ba_c", {127'd0, ba_c}, 128'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'h11);
        chk("bubble t+4 vo_c", {127'd0, vo_c}, 128'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'h12);
        chk("bubble t+5 out_c", {88'd0, out_c}, 128'h11);
        chk("bubble t+5 vo_c", {127'd0, vo_c}, 128'd1);

        // Retrigger, stall during insertion, wide data into the 8-bit instance.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 40'hFF_FFFF_FF20);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 40'h21);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 40'h22);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 40'h23);
        for (int j = 0; j < 6; j++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'h12_3456_7800 + 40'(j));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 40'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 40'h0);

        // Reset between edges while the DEPTH=2 instance counter is 2.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 40'h31);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'h32);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async reset ba_c", {127'd0, ba_c}, 128'd0);
        chk("async reset out_a", {88'd0, out_a}, 128'd0);
        chk("async reset vo_b", {127'd0, vo_b}, 128'd0);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'h3C);
        chk("post reset out_b", {120'd0, out_b}, 128'h3C);
        chk("post reset vo_b", {127'd0, vo_b}, 128'd1);

        // Flush together with bubble.
        for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'h55);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 40'h66);
        chk("flush+bubble out_a", {88'd0, out_a}, 128'd0);
        chk("flush+bubble vo_b", {127'd0, vo_b}, 128'd0);
        chk("flush+bubble ba_c", {127'd0, ba_c}, 128'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'h67);
        chk("after flush out_b", {120'd0, out_b}, 128'h67);

        // Long stall until the counters saturate, then flush.
        for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 40'h77);
        for (int j = 0; j < 70000; j++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 40'h0);
        chk("stall sat a", {112'd0, sc_a}, 128'hFFFF);
        chk("stall sat c", {112'd0, sc_c}, 128'hFFFF);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 40'h0);
        chk("stall flush a", {112'd0, sc_a}, 128'd0);
        chk("stall flush b", {112'd0, sc_b}, 128'd0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
